// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control sequencer for the 8-bit CPU datapath: fetches 32-bit instructions over a
// req/ack port, decodes them and drives register-file/ALU control, PC and retire counter.
module cpu_seq_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int unsigned PC_STEP       = 4,
    parameter int unsigned FETCH_TIMEOUT = 16
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_run,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ack,
    input  logic [31:0] i_imem_rdata,
    output logic [2:0]  o_rf_raddr1,
    output logic [2:0]  o_rf_raddr2,
    output logic [2:0]  o_rf_waddr,
    output logic        o_rf_we,
    output logic [2:0]  o_alu_op,
    output logic        o_imm_sel,
    output logic [7:0]  o_imm_val,
    output logic [31:0] o_pc,
    output logic [15:0] o_instr_count,
    output logic        o_busy,
    output logic        o_err,
    output logic [1:0]  o_err_code
);

    localparam int unsigned    CntW    = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(FETCH_TIMEOUT - 1);
    localparam logic [7:0]     OpMax   = 8'h05;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StDecode,
        StExecute,
        StWriteback,
        StErr
    } state_e;

    state_e          r_state;
    logic [31:0]     r_pc;
    logic [31:0]     r_ir;
    logic [15:0]     r_instr_count;
    logic [CntW-1:0] r_tmo_cnt;
    logic            r_imem_req;
    logic            r_rf_we;
    logic [2:0]      r_alu_op;
    logic            r_imm_sel;
    logic            r_err;
    logic [1:0]      r_err_code;

    logic [7:0]      w_opcode;
    logic            w_legal;
    logic            w_unused;

    assign w_opcode = i_imem_rdata[31:24];
    assign w_legal  = (w_opcode <= OpMax);
    // ir[23:19] and ir[15:11] carry no meaning for this instruction set
    assign w_unused = ^{r_ir[23:19], r_ir[15:11]};

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state       <= StIdle;
            r_pc          <= RESET_PC;
            r_ir          <= 32'h0;
            r_instr_count <= 16'h0;
            r_tmo_cnt     <= '0;
            r_imem_req    <= 1'b0;
            r_rf_we       <= 1'b0;
            r_alu_op      <= 3'b000;
            r_imm_sel     <= 1'b0;
            r_err         <= 1'b0;
            r_err_code    <= 2'b00;
        end else begin
            r_rf_we <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (i_run) begin
                        r_state    <= StFetch;
                        r_imem_req <= 1'b1;
                    end
                end
                StFetch: begin
                    if (i_imem_ack) begin
                        r_ir       <= i_imem_rdata;
                        r_alu_op   <= w_legal ? w_opcode[2:0] : 3'b000;
                        r_imm_sel  <= (w_opcode == 8'h00);
                        r_imem_req <= 1'b0;
                        r_tmo_cnt  <= '0;
                        r_state    <= StDecode;
                    end else if (r_tmo_cnt == CntLast) begin
                        r_imem_req <= 1'b0;
                        r_tmo_cnt  <= '0;
                        r_err      <= 1'b1;
                        r_err_code <= 2'b10;
                        r_state    <= StErr;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + CntW'(1);
                    end
                end
                StDecode: begin
                    if (r_ir[31:24] > OpMax) begin
                        r_err      <= 1'b1;
                        r_err_code <= 2'b01;
                        r_state    <= StErr;
                    end else begin
                        r_state <= StExecute;
                    end
                end
                StExecute: begin
                    // Registered so the pulse lands exactly on the WRITEBACK cycle
                    r_rf_we <= 1'b1;
                    r_state <= StWriteback;
                end
                StWriteback: begin
                    r_pc          <= r_pc + PC_STEP;
                    r_instr_count <= r_instr_count + 16'd1;
                    if (i_run) begin
                        r_state    <= StFetch;
                        r_imem_req <= 1'b1;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StErr: begin
                    r_state <= StErr;
                end
                default: begin
                    r_state <= StIdle;
                end
            endcase
        end
    end

    assign o_imem_req    = r_imem_req;
    assign o_imem_addr   = r_imem_req ? r_pc : 32'h0;
    assign o_rf_raddr1   = r_ir[10:8];
    assign o_rf_raddr2   = r_ir[2:0];
    assign o_rf_waddr    = r_ir[18:16];
    assign o_rf_we       = r_rf_we;
    assign o_alu_op      = r_alu_op;
    assign o_imm_sel     = r_imm_sel;
    assign o_imm_val     = r_ir[7:0];
    assign o_pc          = r_pc;
    assign o_instr_count = r_instr_count;
    assign o_busy        = (r_state != StIdle) && (r_state != StErr);
    assign o_err         = r_err;
    assign o_err_code    = r_err_code;

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Directed self-checking bench for cpu_seq_ctrl: instruction memory model with programmable
// ack delay, plus a second instance with a wrapping reset PC.
module tb_cpu_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        run = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [2:0]  rf_raddr1, rf_raddr2, rf_waddr, alu_op;
    logic        rf_we, imm_sel, busy, err;
    logic [7:0]  imm_val;
    logic [31:0] pc;
    logic [15:0] instr_count;
    logic [1:0]  err_code;

    logic        w2_run = 1'b0;
    logic        w2_req;
    logic [31:0] w2_addr;
    logic        w2_ack;
    logic [31:0] w2_rdata;
    logic [2:0]  w2_raddr1, w2_raddr2, w2_waddr, w2_alu_op;
    logic        w2_rf_we, w2_imm_sel, w2_busy, w2_err;
    logic [7:0]  w2_imm_val;
    logic [31:0] w2_pc;
    logic [15:0] w2_count;
    logic [1:0]  w2_err_code;

    logic [31:0] prog [0:15];
    int          ack_delay  = 0;
    int          req_cycles = 0;
    logic        ack_force  = 1'b0;
    logic        rf_we_seen = 1'b0;
    int          n_checks   = 0;
    int          n_errors   = 0;

    always #5 clk = ~clk;

    cpu_seq_ctrl u_dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_run        (run),
        .o_imem_req   (imem_req),
        .o_imem_addr  (imem_addr),
        .i_imem_ack   (imem_ack),
        .i_imem_rdata (imem_rdata),
        .o_rf_raddr1  (rf_raddr1),
        .o_rf_raddr2  (rf_raddr2),
        .o_rf_waddr   (rf_waddr),
        .o_rf_we      (rf_we),
        .o_alu_op     (alu_op),
        .o_imm_sel    (imm_sel),
        .o_imm_val    (imm_val),
        .o_pc         (pc),
        .o_instr_count(instr_count),
        .o_busy       (busy),
        .o_err        (err),
        .o_err_code   (err_code)
    );

    assign w2_ack   = w2_req;
    assign w2_rdata = 32'h0001_0005;

    cpu_seq_ctrl #(
        .RESET_PC     (32'hFFFF_FFFC),
        .PC_STEP      (4),
        .FETCH_TIMEOUT(16)
    ) u_wrap (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_run        (w2_run),
        .o_imem_req   (w2_req),
        .o_imem_addr  (w2_addr),
        .i_imem_ack   (w2_ack),
        .i_imem_rdata (w2_rdata),
        .o_rf_raddr1  (w2_raddr1),
        .o_rf_raddr2  (w2_raddr2),
        .o_rf_waddr   (w2_waddr),
        .o_rf_we      (w2_rf_we),
        .o_alu_op     (w2_alu_op),
        .o_imm_sel    (w2_imm_sel),
        .o_imm_val    (w2_imm_val),
        .o_pc         (w2_pc),
        .o_instr_count(w2_count),
        .o_busy       (w2_busy),
        .o_err        (w2_err),
        .o_err_code   (w2_err_code)
    );

    // Memory answers after ack_delay request cycles; ack_force drives ack while req is low
    always @(negedge clk) begin
        if (imem_req) begin
            imem_ack   = (req_cycles == ack_delay);
            imem_rdata = prog[imem_addr[5:2]];
            req_cycles = req_cycles + 1;
        end else begin
            imem_ack   = ack_force;
            imem_rdata = 32'h0001_0001;
            req_cycles = 0;
        end
    end

    always @(posedge clk) begin
        if (rf_we) rf_we_seen = 1'b1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        run       = 1'b0;
        ack_force = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        logic [2:0] exp_op [0:3];
        exp_op[0] = 3'b010;
        exp_op[1] = 3'b011;
        exp_op[2] = 3'b100;
        exp_op[3] = 3'b101;
        for (int i = 0; i < 16; i++) prog[i] = 32'h0;

        // Reset state
        do_reset();
        check_eq("rst_pc", pc, 32'h0);
        check_eq("rst_req", imem_req, 1'b0);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_err", {err, err_code}, 3'b000);
        check_eq("rst_count", instr_count, 16'h0);
        check_eq("rst_ctl", {alu_op, imm_sel, imm_val, rf_we}, 13'h0);

        // 1: loadi r3, 0x2A with zero-wait memory
        prog[0]   = 32'h0003_002A;
        ack_delay = 0;
        run       = 1'b1;
        tick();
        check_eq("t1_fetch_req", imem_req, 1'b1);
        check_eq("t1_fetch_addr", imem_addr, 32'h0);
        check_eq("t1_busy", busy, 1'b1);
        tick();
        check_eq("t1_dec_imm_sel", imm_sel, 1'b1);
        check_eq("t1_dec_alu_op", alu_op, 3'b000);
        check_eq("t1_dec_imm_val", imm_val, 8'h2A);
        check_eq("t1_dec_req", imem_req, 1'b0);
        tick();
        check_eq("t1_exe_we", rf_we, 1'b0);
        tick();
        run = 1'b0;
        check_eq("t1_wb_we", rf_we, 1'b1);
        check_eq("t1_wb_waddr", rf_waddr, 3'd3);
        check_eq("t1_wb_pc", pc, 32'h0);
        tick();
        check_eq("t1_pc", pc, 32'h4);
        check_eq("t1_count", instr_count, 16'd1);
        check_eq("t1_idle_busy", busy, 1'b0);
        check_eq("t1_idle_we", rf_we, 1'b0);

        // 2: add/sub/and/or back to back
        do_reset();
        prog[0] = 32'h0201_0203;
        prog[1] = 32'h0304_0506;
        prog[2] = 32'h0407_0102;
        prog[3] = 32'h0502_0304;
        run     = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            if (k == 16) run = 1'b0;
            if (k % 4 == 2) check_eq("t2_alu_op", alu_op, exp_op[(k - 2) / 4]);
            if (k == 2) begin
                check_eq("t2_raddr", {rf_waddr, rf_raddr1, rf_raddr2, imm_sel}, {9'o123, 1'b0});
            end
            check_eq("t2_rf_we", rf_we, (k % 4 == 0));
        end
        tick();
        check_eq("t2_pc", pc, 32'd16);
        check_eq("t2_count", instr_count, 16'd4);

        // 3: five wait cycles, then ack withheld until timeout
        do_reset();
        prog[0]   = 32'h0005_0011;
        ack_delay = 5;
        run       = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            check_eq("t3_req", imem_req, (k <= 6));
            if (k <= 6) check_eq("t3_addr", imem_addr, 32'h0);
            check_eq("t3_rf_we", rf_we, (k == 9));
            if (k == 9) ack_delay = 100;
        end
        for (int k = 10; k <= 25; k++) tick();
        check_eq("t3_last_fetch_req", imem_req, 1'b1);
        check_eq("t3_last_fetch_addr", imem_addr, 32'h4);
        tick();
        check_eq("t3_err", {err, err_code}, 3'b110);
        check_eq("t3_req_off", imem_req, 1'b0);
        check_eq("t3_pc", pc, 32'h4);
        check_eq("t3_busy", busy, 1'b0);

        // 4: illegal opcode traps; stray ack and run toggles are ignored
        do_reset();
        prog[0]    = 32'h0700_0000;
        ack_delay  = 0;
        rf_we_seen = 1'b0;
        run        = 1'b1;
        tick();
        tick();
        tick();
        check_eq("t4_err", {err, err_code}, 3'b101);
        check_eq("t4_busy", busy, 1'b0);
        for (int i = 0; i < 6; i++) begin
            run       = i[0];
            ack_force = 1'b1;
            tick();
            check_eq("t4_err_sticky", {err, err_code, imem_req}, 4'b1010);
        end
        ack_force = 1'b0;
        check_eq("t4_no_we", rf_we_seen, 1'b0);
        check_eq("t4_pc", pc, 32'h0);
        check_eq("t4_count", instr_count, 16'h0);

        // 5: run dropped during EXECUTE still completes writeback
        do_reset();
        prog[0] = 32'h0002_0033;
        run     = 1'b1;
        tick();
        tick();
        tick();
        run = 1'b0;
        tick();
        check_eq("t5_wb_we", rf_we, 1'b1);
        tick();
        check_eq("t5_pc", pc, 32'h4);
        check_eq("t5_count", instr_count, 16'd1);
        check_eq("t5_busy", busy, 1'b0);
        tick();
        check_eq("t5_idle_req", imem_req, 1'b0);

        // 6: reset mid-fetch clears everything
        ack_delay = 100;
        run       = 1'b1;
        tick();
        check_eq("t6_fetch_addr", imem_addr, 32'h4);
        tick();
        check_eq("t6_fetch_req", imem_req, 1'b1);
        rst = 1'b0;
        tick();
        check_eq("t6_req", imem_req, 1'b0);
        check_eq("t6_addr", imem_addr, 32'h0);
        check_eq("t6_pc", pc, 32'h0);
        check_eq("t6_count", instr_count, 16'h0);
        check_eq("t6_busy", busy, 1'b0);
        check_eq("t6_ctl", {rf_waddr, imm_val, imm_sel, alu_op}, 15'h0);
        rst       = 1'b1;
        run       = 1'b0;
        ack_delay = 0;

        // 6b: PC wraps from 0xFFFF_FFFC to 0
        check_eq("t6_wrap_rst_pc", w2_pc, 32'hFFFF_FFFC);
        w2_run = 1'b1;
        tick();
        check_eq("t6_wrap_addr", w2_addr, 32'hFFFF_FFFC);
        tick();
        tick();
        tick();
        w2_run = 1'b0;
        check_eq("t6_wrap_we", w2_rf_we, 1'b1);
        tick();
        check_eq("t6_wrap_pc", w2_pc, 32'h0);
        check_eq("t6_wrap_count", w2_count, 16'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
